csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameters SHALL be:
- MVENDORID, 32'h616b6562, mvendorid read value.
- MARCHID, 32'h05318008, marchid read value.
- NUM_HPM, 4, number of mhpmcounter3..(3+NUM_HPM-1), range 1..8.
REQ-002 Ports SHALL be, in order:
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- wen  in  1  CSR write request this cycle.
- op  in  2  write op: 00 RW, 01 RS (set), 10 RC (clear), 11 reserved, treated as RW.
- addr  in  12  CSR address for read and write.
- wdata  in  32  write operand.
- rdata  out  32  read data for addr, combinational.
- illegal  out  1  combinational; addr unimplemented, or wen to a read-only address.
- instret_inc  in  1  one instruction retired this cycle.
- hpm_event  in  NUM_HPM  per-counter increment strobes.
- trap_valid  in  1  trap entry this cycle.
- trap_cause  in  32  mcause value on trap.
- trap_pc  in  32  mepc value on trap.
- mret  in  1  return from trap this cycle.
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- mie_o  out  1  current mstatus.MIE.

Function
REQ-003 Implemented CSRs SHALL be misa 0x301 (const RV32I, 32'h40000100), mvendorid 0xF11, marchid 0xF12, mstatus 0x300 (MIE bit3, MPIE bit7, others read 0), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcountinhibit 0x320, mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, read-only aliases cycle/cycleh 0xC00/0xC80 and instret/instreth 0xC02/0xC82.
REQ-004 Write value SHALL be wdata (RW), old|wdata (RS), old&~wdata (RC), applied on the rising edge when wen=1 and illegal=0.
REQ-005 A write with illegal=1 SHALL leave all state unchanged.
REQ-006 mtvec[1:0] and mepc[1:0] SHALL always read 0, in direct mode only.
REQ-007 Each 64-bit counter SHALL increment by 1 per cycle for mcycle, per instret_inc for minstret, and per hpm_event[i] for mhpmcounter; no increment while its mcountinhibit bit (CY=0, IR=2, HPMn=n) is set.
REQ-008 A write to a counter half SHALL replace that half; the other half SHALL hold, and that cycle's increment is dropped for that counter.
REQ-009 A counter at 64'hFFFF_FFFF_FFFF_FFFF SHALL wrap to 0 on increment; a low-half carry propagates into the high half in the same cycle.
REQ-010 rdata SHALL return the pre-edge value (read-before-write, no increment bypass); an unimplemented addr SHALL give rdata=0.
REQ-011 On trap_valid: mepc<=trap_pc, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-012 On mret with trap_valid=0: MIE<=MPIE, MPIE<=1.
REQ-013 Priority SHALL be trap_valid > mret > CSR write; a lower-priority write to the same register is dropped, while a write to other CSRs proceeds.
REQ-014 Counters SHALL keep counting during trap and mret cycles.

Reset
REQ-015 On reset=1 at a clock edge, all counters, mscratch, mepc, mcause, mtvec, mcountinhibit and MIE SHALL clear to 0 and MPIE SHALL set to 1; reset overrides every concurrent input.
REQ-016 During reset, outputs SHALL reflect the held state: mtvec_o=0, mepc_o=0, mie_o=0 after the first reset edge.

Configuration
REQ-017 With CSR_HPM_EN defined, mhpmcounter3+i (0xB03+i/0xB83+i) and mhpmevent-free counting SHALL exist for i<NUM_HPM.
REQ-018 Without CSR_HPM_EN, those addresses SHALL be unimplemented (illegal=1, rdata=0), hpm_event SHALL be ignored, and mcountinhibit bits 3+ SHALL read 0.

Structure
REQ-019 A package csr_pkg SHALL hold the CSR address localparams, the op encoding enum, the misa constant and the mstatus bit positions.
REQ-020 Sub-module csr_counter64 SHALL implement one 64-bit counter (inc, inhibit, lo/hi write); it is instantiated for mcycle, minstret and each HPM counter.

Verification
REQ-021 Directed scenarios:
- Reset, then 10 idle cycles; read 0xB00 -> 10, 0xB80 -> 0.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0, then 1 cycle -> mcycle=0, mcycleh=1.
- mscratch RW 0xF0; RS 0x0F; RC 0x30 -> reads 0xF0, 0xFF, 0xCF.
- wen=1 to 0xC00 -> illegal=1, cycle counter unaffected; read 0x7FF -> rdata=0, illegal=1.
- MIE=1, trap_valid with pc 0x104, cause 11, plus same-cycle wen to mepc=0x200 -> mepc_o=0x104, mcause=11, mie_o=0, MPIE=1; then mret -> mie_o=1.
- mcountinhibit=0x5 with instret_inc=1 for 5 cycles -> mcycle and minstret frozen; clear inhibit -> both resume.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
//   - CSR address map
//   - write-op encoding and the helper that applies it
//   - misa constant and mstatus / mcountinhibit bit positions
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MISA          = 12'h301;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER3  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTER3H = 12'hB83;
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH      = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
  localparam logic [11:0] CSR_MARCHID       = 12'hF12;

  localparam logic [31:0] MISA_RV32I = 32'h4000_0100;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  localparam int INH_CY       = 0;
  localparam int INH_IR       = 2;
  localparam int INH_HPM_BASE = 3;

  typedef enum logic [1:0] {
    CSR_OP_RW   = 2'b00,
    CSR_OP_RS   = 2'b01,
    CSR_OP_RC   = 2'b10,
    CSR_OP_RSVD = 2'b11
  } csr_op_e;

  // Reserved encoding behaves as a plain write.
  function automatic logic [31:0] csr_apply_op(input csr_op_e op,
                                               input logic [31:0] old_val,
                                               input logic [31:0] operand);
    case (op)
      CSR_OP_RS: return old_val | operand;
      CSR_OP_RC: return old_val & ~operand;
      default:   return operand;
    endcase
  endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: one 64-bit event counter with split 32-bit write access.
// Ports:
//   i_clock    clock (rising edge)
//   i_reset    synchronous active-high reset, clears the count
//   i_inc      count one event this cycle
//   i_inhibit  suppress counting
//   i_wr_lo    replace bits [31:0] with i_wdata
//   i_wr_hi    replace bits [63:32] with i_wdata
//   i_wdata    write value
//   o_value    current count
// A write to either half wins over that cycle's increment; the untouched half holds.
module csr_counter64 (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_inc,
  input  logic        i_inhibit,
  input  logic        i_wr_lo,
  input  logic        i_wr_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_value
);

  logic [63:0] r_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_wr_lo) begin
      r_cnt[31:0] <= i_wdata;
    end else if (i_wr_hi) begin
      r_cnt[63:32] <= i_wdata;
    end else if (i_inc && !i_inhibit) begin
      r_cnt <= r_cnt + 64'd1;
    end
  end

  assign o_value = r_cnt;

endmodule

// File: rtl/csr_file.sv
// csr_file: RV32 machine-mode CSR file with trap entry/return and counters.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   wen, op, addr, wdata    CSR write request (RW/RS/RC) at addr
//   rdata, illegal          combinational read of addr and access check
//   instret_inc, hpm_event  counter increment strobes
//   trap_valid, trap_cause, trap_pc, mret   trap entry / return
//   mtvec_o, mepc_o, mie_o  current mtvec, mepc and mstatus.MIE
// Build option: define CSR_HPM_EN to add mhpmcounter3.. (NUM_HPM of them);
// otherwise those addresses are unimplemented and hpm_event is ignored.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MVENDORID = 32'h616b_6562,
  parameter logic [31:0] MARCHID   = 32'h0531_8008,
  parameter int          NUM_HPM   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wen,
  input  logic [1:0]         op,
  input  logic [11:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               illegal,
  input  logic               instret_inc,
  input  logic [NUM_HPM-1:0] hpm_event,
  input  logic               trap_valid,
  input  logic [31:0]        trap_cause,
  input  logic [31:0]        trap_pc,
  input  logic               mret,
  output logic [31:0]        mtvec_o,
  output logic [31:0]        mepc_o,
  output logic               mie_o
);

  logic [31:0] r_mscratch;
  logic [31:0] r_mtvec;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mcountinhibit;
  logic        r_mie;
  logic        r_mpie;

  logic [63:0] w_mcycle;
  logic [63:0] w_minstret;
  logic [31:0] w_rdata;
  logic        w_impl;
  logic        w_ro;
  logic        w_wr_ok;
  logic [31:0] w_wval;

`ifdef CSR_HPM_EN
  localparam logic [31:0] INH_MASK =
    32'h5 | (((32'h1 << NUM_HPM) - 32'h1) << INH_HPM_BASE);
  logic [63:0] w_hpm_val [NUM_HPM];
`else
  localparam logic [31:0] INH_MASK = 32'h5;
  logic w_unused_hpm;
  assign w_unused_hpm = ^hpm_event;
`endif

  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b1;
    case (addr)
      CSR_MISA:          w_rdata = MISA_RV32I;
      CSR_MVENDORID:     w_rdata = MVENDORID;
      CSR_MARCHID:       w_rdata = MARCHID;
      CSR_MSTATUS: begin
        w_rdata[MSTATUS_MIE_BIT]  = r_mie;
        w_rdata[MSTATUS_MPIE_BIT] = r_mpie;
      end
      CSR_MTVEC:         w_rdata = r_mtvec;
      CSR_MSCRATCH:      w_rdata = r_mscratch;
      CSR_MEPC:          w_rdata = r_mepc;
      CSR_MCAUSE:        w_rdata = r_mcause;
      CSR_MCOUNTINHIBIT: w_rdata = r_mcountinhibit;
      CSR_MCYCLE,   CSR_CYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_minstret[63:32];
      default:           w_impl = 1'b0;
    endcase
`ifdef CSR_HPM_EN
    for (int i = 0; i < NUM_HPM; i++) begin
      if (addr == CSR_MHPMCOUNTER3 + 12'(i)) begin
        w_rdata = w_hpm_val[i][31:0];
        w_impl  = 1'b1;
      end
      if (addr == CSR_MHPMCOUNTER3H + 12'(i)) begin
        w_rdata = w_hpm_val[i][63:32];
        w_impl  = 1'b1;
      end
    end
`endif
  end

  // Addresses 0xC00-0xFFF are read-only by the RISC-V CSR address convention.
  assign w_ro    = (addr[11:10] == 2'b11);
  assign illegal = !w_impl || (wen && w_ro);
  assign rdata   = w_rdata;
  assign w_wr_ok = wen && !illegal;
  // Read-modify-write operand is the pre-edge read value of the same address.
  assign w_wval  = csr_apply_op(csr_op_e'(op), w_rdata, wdata);

  csr_counter64 u_mcycle (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_inc     (1'b1),
    .i_inhibit (r_mcountinhibit[INH_CY]),
    .i_wr_lo   (w_wr_ok && (addr == CSR_MCYCLE)),
    .i_wr_hi   (w_wr_ok && (addr == CSR_MCYCLEH)),
    .i_wdata   (w_wval),
    .o_value   (w_mcycle)
  );

  csr_counter64 u_minstret (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_inc     (instret_inc),
    .i_inhibit (r_mcountinhibit[INH_IR]),
    .i_wr_lo   (w_wr_ok && (addr == CSR_MINSTRET)),
    .i_wr_hi   (w_wr_ok && (addr == CSR_MINSTRETH)),
    .i_wdata   (w_wval),
    .o_value   (w_minstret)
  );

`ifdef CSR_HPM_EN
  for (genvar gi = 0; gi < NUM_HPM; gi++) begin : g_hpm
    csr_counter64 u_hpm (
      .i_clock   (clock),
      .i_reset   (reset),
      .i_inc     (hpm_event[gi]),
      .i_inhibit (r_mcountinhibit[INH_HPM_BASE+gi]),
      .i_wr_lo   (w_wr_ok && (addr == CSR_MHPMCOUNTER3 + 12'(gi))),
      .i_wr_hi   (w_wr_ok && (addr == CSR_MHPMCOUNTER3H + 12'(gi))),
      .i_wdata   (w_wval),
      .o_value   (w_hpm_val[gi])
    );
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mscratch      <= '0;
      r_mtvec         <= '0;
      r_mepc          <= '0;
      r_mcause        <= '0;
      r_mcountinhibit <= '0;
      r_mie           <= 1'b0;
      r_mpie          <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        case (addr)
          CSR_MTVEC:         r_mtvec         <= w_wval & ~32'h3;
          CSR_MSCRATCH:      r_mscratch      <= w_wval;
          CSR_MCOUNTINHIBIT: r_mcountinhibit <= w_wval & INH_MASK;
          default: ;
        endcase
      end
      // Trap owns mepc/mcause/mstatus this cycle; mret owns only mstatus.
      if (trap_valid) begin
        r_mepc   <= trap_pc & ~32'h3;
        r_mcause <= trap_cause;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else begin
        if (mret) begin
          r_mie  <= r_mpie;
          r_mpie <= 1'b1;
        end else if (w_wr_ok && (addr == CSR_MSTATUS)) begin
          r_mie  <= w_wval[MSTATUS_MIE_BIT];
          r_mpie <= w_wval[MSTATUS_MPIE_BIT];
        end
        if (w_wr_ok && (addr == CSR_MEPC))
          r_mepc <= w_wval & ~32'h3;
        if (w_wr_ok && (addr == CSR_MCAUSE))
          r_mcause <= w_wval;
      end
    end
  end

  assign mtvec_o = r_mtvec;
  assign mepc_o  = r_mepc;
  assign mie_o   = r_mie;

endmodule

// File: tb/tb_csr_file.sv
module tb_csr_file;

  localparam int NUM_HPM = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic               wen;
  logic [1:0]         op;
  logic [11:0]        addr;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               illegal;
  logic               instret_inc;
  logic [NUM_HPM-1:0] hpm_event;
  logic               trap_valid;
  logic [31:0]        trap_cause;
  logic [31:0]        trap_pc;
  logic               mret;
  logic [31:0]        mtvec_o;
  logic [31:0]        mepc_o;
  logic               mie_o;

  int checks = 0;
  int failures = 0;

  always #10 clock = ~clock;

  csr_file #(.NUM_HPM(NUM_HPM)) dut (
    .clock(clock), .reset(reset), .wen(wen), .op(op), .addr(addr),
    .wdata(wdata), .rdata(rdata), .illegal(illegal),
    .instret_inc(instret_inc), .hpm_event(hpm_event),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret(mret), .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] m_cyc, m_ins;
  logic [63:0] m_hpm [NUM_HPM];
  logic [31:0] m_scr, m_tvec, m_epc, m_cause, m_inh;
  bit          m_mie, m_mpie;

  function automatic bit m_is_ro(input logic [11:0] a);
    return a inside {12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12};
  endfunction

  function automatic logic [31:0] m_inh_mask();
    logic [31:0] m = 32'h5;
`ifdef CSR_HPM_EN
    for (int i = 0; i < NUM_HPM; i++) m[3+i] = 1'b1;
`endif
    return m;
  endfunction

  // {implemented, value}
  function automatic logic [32:0] m_read(input logic [11:0] a);
    case (a)
      12'h301: return {1'b1, 32'h4000_0100};
      12'hF11: return {1'b1, 32'h616b_6562};
      12'hF12: return {1'b1, 32'h0531_8008};
      12'h300: return {1'b1, 24'h0, m_mpie, 3'b0, m_mie, 3'b0};
      12'h305: return {1'b1, m_tvec};
      12'h340: return {1'b1, m_scr};
      12'h341: return {1'b1, m_epc};
      12'h342: return {1'b1, m_cause};
      12'h320: return {1'b1, m_inh};
      12'hB00, 12'hC00: return {1'b1, m_cyc[31:0]};
      12'hB80, 12'hC80: return {1'b1, m_cyc[63:32]};
      12'hB02, 12'hC02: return {1'b1, m_ins[31:0]};
      12'hB82, 12'hC82: return {1'b1, m_ins[63:32]};
      default: begin
`ifdef CSR_HPM_EN
        for (int i = 0; i < NUM_HPM; i++) begin
          if (a == 12'hB03 + 12'(i)) return {1'b1, m_hpm[i][31:0]};
          if (a == 12'hB83 + 12'(i)) return {1'b1, m_hpm[i][63:32]};
        end
`endif
        return 33'h0;
      end
    endcase
  endfunction

  function automatic logic [63:0] m_count(input logic [63:0] v, input bit wlo,
                                          input bit whi, input logic [31:0] wv,
                                          input bit tick);
    if (wlo) return {v[63:32], wv};
    if (whi) return {wv, v[31:0]};
    return tick ? v + 64'd1 : v;
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [32:0] rd;
    logic [31:0] wv;
    bit          wr;
    logic [63:0] n_cyc, n_ins;
    logic [63:0] n_hpm [NUM_HPM];
    logic [31:0] n_scr, n_tvec, n_epc, n_cause, n_inh;
    bit          n_mie, n_mpie;
    if (reset) begin
      m_cyc = 0; m_ins = 0; m_scr = 0; m_tvec = 0; m_epc = 0; m_cause = 0;
      m_inh = 0; m_mie = 0; m_mpie = 1;
      for (int i = 0; i < NUM_HPM; i++) m_hpm[i] = 0;
      return;
    end
    rd = m_read(addr);
    wr = wen && rd[32] && !m_is_ro(addr);
    case (op)
      2'b01:   wv = rd[31:0] | wdata;
      2'b10:   wv = rd[31:0] & ~wdata;
      default: wv = wdata;
    endcase
    n_cyc = m_count(m_cyc, wr && addr == 12'hB00, wr && addr == 12'hB80, wv, !m_inh[0]);
    n_ins = m_count(m_ins, wr && addr == 12'hB02, wr && addr == 12'hB82, wv,
                    instret_inc && !m_inh[2]);
    for (int i = 0; i < NUM_HPM; i++) begin
      n_hpm[i] = m_hpm[i];
`ifdef CSR_HPM_EN
      n_hpm[i] = m_count(m_hpm[i], wr && addr == 12'hB03 + 12'(i),
                         wr && addr == 12'hB83 + 12'(i), wv,
                         hpm_event[i] && !m_inh[3+i]);
`endif
    end
    n_scr   = (wr && addr == 12'h340) ? wv : m_scr;
    n_tvec  = (wr && addr == 12'h305) ? (wv & ~32'h3) : m_tvec;
    n_inh   = (wr && addr == 12'h320) ? (wv & m_inh_mask()) : m_inh;
    n_epc   = m_epc; n_cause = m_cause; n_mie = m_mie; n_mpie = m_mpie;
    if (trap_valid) begin
      n_epc = trap_pc & ~32'h3; n_cause = trap_cause; n_mpie = m_mie; n_mie = 0;
    end else begin
      if (mret) begin
        n_mie = m_mpie; n_mpie = 1;
      end else if (wr && addr == 12'h300) begin
        n_mie = wv[3]; n_mpie = wv[7];
      end
      if (wr && addr == 12'h341) n_epc = wv & ~32'h3;
      if (wr && addr == 12'h342) n_cause = wv;
    end
    m_cyc = n_cyc; m_ins = n_ins; m_scr = n_scr; m_tvec = n_tvec; m_inh = n_inh;
    m_epc = n_epc; m_cause = n_cause; m_mie = n_mie; m_mpie = n_mpie;
    for (int i = 0; i < NUM_HPM; i++) m_hpm[i] = n_hpm[i];
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wen = 0; op = 0; wdata = 0; instret_inc = 0; hpm_event = '0;
    trap_valid = 0; trap_cause = 0; trap_pc = 0; mret = 0;
  endtask

  // Check outputs against the model, then take one clock edge.
  task automatic step();
    logic [32:0] rd;
    #1;
    rd = m_read(addr);
    chk("rdata", rdata, rd[31:0]);
    chk("illegal", illegal, !rd[32] || (wen && m_is_ro(addr)));
    chk("mtvec_o", mtvec_o, m_tvec);
    chk("mepc_o", mepc_o, m_epc);
    chk("mie_o", mie_o, m_mie);
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic wr(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
    idle();
    wen = 1; addr = a; op = o; wdata = d;
    step();
    wen = 0;
  endtask

  task automatic peek(input string tag, input logic [11:0] a, input logic [31:0] exp);
    idle();
    addr = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  logic [11:0] alist [22] = '{12'h300, 12'h301, 12'h305, 12'h320, 12'h340, 12'h341,
                              12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                              12'hC80, 12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hB03,
                              12'hB04, 12'hB83, 12'hB86, 12'h7FF};
  logic [63:0] snap_cyc, snap_ins;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1; addr = 12'h0;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    #1;
    chk("rst_mtvec", mtvec_o, 0);
    chk("rst_mepc", mepc_o, 0);
    chk("rst_mie", mie_o, 0);
    step();
    reset = 0;

    // 10 idle cycles after reset
    repeat (10) step();
    peek("cyc10_lo", 12'hB00, 32'd10);
    peek("cyc10_hi", 12'hB80, 32'd0);

    // low-half carry into high half
    wr(12'hB00, 2'b00, 32'hFFFF_FFFF);
    wr(12'hB80, 2'b00, 32'h0);
    idle();
    step();
    peek("carry_lo", 12'hB00, 32'h0);
    peek("carry_hi", 12'hB80, 32'h1);

    // mscratch RW / RS / RC
    wr(12'h340, 2'b00, 32'hF0);
    peek("scr_rw", 12'h340, 32'hF0);
    wr(12'h340, 2'b01, 32'h0F);
    peek("scr_rs", 12'h340, 32'hFF);
    wr(12'h340, 2'b10, 32'h30);
    peek("scr_rc", 12'h340, 32'hCF);

    // write to read-only alias, then unimplemented address
    idle();
    wen = 1; addr = 12'hC00; op = 2'b00; wdata = 32'h0;
    #1;
    chk("ro_illegal", illegal, 1);
    step();
    peek("ro_cyc", 12'hC00, m_cyc[31:0]);
    peek("unimpl_rd", 12'h7FF, 32'h0);
    chk("unimpl_ill", illegal, 1);

    // trap beats same-cycle mepc write, then mret
    wr(12'h300, 2'b01, 32'h8);
    idle();
    trap_valid = 1; trap_pc = 32'h104; trap_cause = 32'd11;
    wen = 1; addr = 12'h341; op = 2'b00; wdata = 32'h200;
    step();
    peek("trap_mcause", 12'h342, 32'd11);
    chk("trap_mepc", mepc_o, 32'h104);
    chk("trap_mie", mie_o, 0);
    peek("trap_mstatus", 12'h300, 32'h80);
    idle();
    mret = 1;
    step();
    idle();
    #1;
    chk("mret_mie", mie_o, 1);

    // counter inhibit
    wr(12'h320, 2'b00, 32'h5);
    snap_cyc = m_cyc; snap_ins = m_ins;
    idle();
    instret_inc = 1;
    repeat (5) step();
    peek("inh_cyc", 12'hB00, snap_cyc[31:0]);
    peek("inh_ins", 12'hB02, snap_ins[31:0]);
    wr(12'h320, 2'b10, 32'h5);
    idle();
    instret_inc = 1;
    repeat (2) step();
    peek("res_cyc", 12'hB00, snap_cyc[31:0] + 32'd2);
    peek("res_ins", 12'hB02, snap_ins[31:0] + 32'd2);

    // randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      addr = ($urandom_range(0, 9) == 0) ? 12'($urandom) : alist[$urandom_range(0, 21)];
      wen = ($urandom_range(0, 2) != 0);
      op = 2'($urandom);
      wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      instret_inc = 1'($urandom);
      hpm_event = NUM_HPM'($urandom);
      trap_valid = ($urandom_range(0, 15) == 0);
      trap_cause = $urandom;
      trap_pc = $urandom;
      mret = ($urandom_range(0, 11) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
